// File: rtl/mem_arb_defs.sv
// Shared definitions for the frame-buffer memory arbiter: op encodings,
// default bus widths and requester port assignments.
package mem_arb_defs;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int ARB_NUM_REQ = 5;
    localparam int ARB_ADDR_W  = 16;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_WBEN_W  = ARB_DATA_W / 8;

    // Requester port assignments; unlisted indices are reserved.
    localparam int REQ_FILL_RECT = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant selection. The search starts at ptr and
// wraps modulo N; the pointer register itself lives in the parent.
module rr_arbiter #(
    parameter  int N     = 5,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    // First set request at or after ptr, wrapping past N-1 back to 0.
    always_comb begin
        logic             found;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the drawing engines and the single-port
// frame-buffer SRAM. Grants one request per cycle, issues it to the SRAM on
// the following cycle and returns read data on a shared broadcast bus with a
// one-hot completion strobe.
// Optional feature macro: ARB_WRITE_ACK_EN -- writes also produce a
// completion strobe (with bcast_data left unchanged).
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int WBEN_W     = ARB_WBEN_W,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [NUM_REQ-1:0]        req_rts,
    output logic [NUM_REQ-1:0]        req_rtr,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*WBEN_W-1:0] req_wben,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [WBEN_W-1:0]         mem_wben,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [DATA_W-1:0]         bcast_data,
    output logic [NUM_REQ-1:0]        bcast_xfc
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]  ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              transfer;

    logic              sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [WBEN_W-1:0] sel_wben;

    logic [IDX_W-1:0]  issue_id;
    logic              launch;

    // Tracking pipeline: one entry per issued access, MEM_RD_LAT deep so the
    // last stage lines up with valid mem_rdata.
    logic [MEM_RD_LAT-1:0] trk_valid;
    logic [MEM_RD_LAT-1:0] trk_read;
    logic [IDX_W-1:0]      trk_id [MEM_RD_LAT];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_rts),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // grant is already qualified by req_rts, so any grant bit is a transfer.
    assign req_rtr  = grant;
    assign transfer = |(req_rts & grant);

    // Select the granted engine's request fields.
    always_comb begin
        sel_op   = OP_READ;
        sel_addr = '0;
        sel_data = '0;
        sel_wben = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op   = req_op[i];
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_wben = req_wben[i*WBEN_W +: WBEN_W];
            end
        end
    end

    // Round-robin pointer: moves just past the winner on each transfer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // SRAM issue register; buses hold their last values on idle cycles.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wben  <= '0;
            issue_id  <= '0;
        end else begin
            mem_en <= transfer;
            mem_we <= transfer && (sel_op == OP_WRITE);
            if (transfer) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_data;
                mem_wben  <= (sel_op == OP_WRITE) ? sel_wben : '0;
                issue_id  <= grant_idx;
            end
        end
    end

`ifdef ARB_WRITE_ACK_EN
    assign launch = mem_en;
`else
    assign launch = mem_en && !mem_we;
`endif

    // Shift issued accesses toward the completion stage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            trk_valid <= '0;
            trk_read  <= '0;
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                trk_id[i] <= '0;
            end
        end else begin
            for (int i = MEM_RD_LAT - 1; i > 0; i--) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_read[i]  <= trk_read[i-1];
                trk_id[i]    <= trk_id[i-1];
            end
            trk_valid[0] <= launch;
            trk_read[0]  <= !mem_we;
            trk_id[0]    <= issue_id;
        end
    end

    // Completion: one-cycle strobe to the owner; reads also capture data.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bcast_xfc  <= '0;
            bcast_data <= '0;
        end else if (trk_valid[MEM_RD_LAT-1]) begin
            bcast_xfc <= NUM_REQ'(1) << trk_id[MEM_RD_LAT-1];
            if (trk_read[MEM_RD_LAT-1]) begin
                bcast_data <= mem_rdata;
            end
        end else begin
            bcast_xfc <= '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency SRAM model.
module tb_mem_arbiter;
    import mem_arb_defs::*;

    localparam int N  = 5;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 4;

    logic            clk;
    logic            rst_;
    logic [N-1:0]    req_rts;
    logic [N-1:0]    req_rtr;
    logic [N-1:0]    req_op;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*BW-1:0] req_wben;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [BW-1:0]   mem_wben;
    logic [DW-1:0]   mem_rdata;
    logic [DW-1:0]   bcast_data;
    logic [N-1:0]    bcast_xfc;

    int tests;
    int fails;

    logic [DW-1:0] sram [256];

    mem_arbiter dut (
        .clk        (clk),
        .rst_       (rst_),
        .req_rts    (req_rts),
        .req_rtr    (req_rtr),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_wben   (req_wben),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wben   (mem_wben),
        .mem_rdata  (mem_rdata),
        .bcast_data (bcast_data),
        .bcast_xfc  (bcast_xfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM, one cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_wben[b]) sram[mem_addr[7:0]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic [N-1:0] rts;
        logic [N-1:0] rtr;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [BW-1:0] wben);
        req_op[idx]              = op;
        req_addr[idx*AW +: AW]   = addr;
        req_data[idx*DW +: DW]   = data;
        req_wben[idx*BW +: BW]   = wben;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_ = 1'b0;
        req_rts = '0;
        req_op = '0;
        req_addr = '0;
        req_data = '0;
        req_wben = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        sram[8'h10] = 32'hDEADBEEF;
        sram[8'h20] = 32'h11111111;

        vecs[0]  = '{5'b00000, 5'b00000};
        vecs[1]  = '{5'b11111, 5'b00001};
        vecs[2]  = '{5'b11111, 5'b00010};
        vecs[3]  = '{5'b11111, 5'b00100};
        vecs[4]  = '{5'b11111, 5'b01000};
        vecs[5]  = '{5'b11111, 5'b10000};
        vecs[6]  = '{5'b11111, 5'b00001};
        vecs[7]  = '{5'b11111, 5'b00010};
        vecs[8]  = '{5'b11111, 5'b00100};
        vecs[9]  = '{5'b11111, 5'b01000};
        vecs[10] = '{5'b11111, 5'b10000};
        vecs[11] = '{5'b10001, 5'b00001};
        vecs[12] = '{5'b10001, 5'b10000};
        vecs[13] = '{5'b10001, 5'b00001};
        vecs[14] = '{5'b10001, 5'b10000};
        vecs[15] = '{5'b00100, 5'b00100};
        vecs[16] = '{5'b00100, 5'b00100};
        vecs[17] = '{5'b01010, 5'b01000};
        vecs[18] = '{5'b01010, 5'b00010};
        vecs[19] = '{5'b00000, 5'b00000};
        vecs[20] = '{5'b00011, 5'b00001};
        vecs[21] = '{5'b00011, 5'b00010};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rtr", 64'(req_rtr), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_bcast_xfc", 64'(bcast_xfc), 64'd0);
        chk("rst_bcast_data", 64'(bcast_data), 64'd0);
        rst_ = 1'b1;

        // Single read from the fill-rect engine
        @(negedge clk);
        set_req(REQ_FILL_RECT, OP_READ, 16'h0010, 32'h0, 4'hF);
        req_rts = 5'b00010;
        #1 chk("rd_rtr", 64'(req_rtr), 64'b00010);
        @(negedge clk);
        req_rts = '0;
        chk("rd_mem_en", 64'(mem_en), 64'd1);
        chk("rd_mem_we", 64'(mem_we), 64'd0);
        chk("rd_mem_addr", 64'(mem_addr), 64'h0010);
        chk("rd_mem_wben", 64'(mem_wben), 64'd0);
        @(negedge clk);
        chk("rd_xfc_early", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
        chk("rd_xfc", 64'(bcast_xfc), 64'b00010);
        chk("rd_data", 64'(bcast_data), 64'hDEADBEEF);
        @(negedge clk);
        chk("rd_xfc_drop", 64'(bcast_xfc), 64'd0);
        chk("rd_data_hold", 64'(bcast_data), 64'hDEADBEEF);

        // Write then read of the same address, consecutive grants
        @(negedge clk);
        set_req(1, OP_WRITE, 16'h0020, 32'hA5A5A5A5, 4'b0011);
        req_rts = 5'b00010;
        #1 chk("wr_rtr", 64'(req_rtr), 64'b00010);
        @(negedge clk);
        chk("wr_mem_en", 64'(mem_en), 64'd1);
        chk("wr_mem_we", 64'(mem_we), 64'd1);
        chk("wr_mem_addr", 64'(mem_addr), 64'h0020);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        chk("wr_mem_wben", 64'(mem_wben), 64'b0011);
        set_req(1, OP_READ, 16'h0020, 32'hA5A5A5A5, 4'b0011);
        #1 chk("raw_rtr", 64'(req_rtr), 64'b00010);
        @(negedge clk);
        req_rts = '0;
        chk("raw_mem_we", 64'(mem_we), 64'd0);
        chk("raw_mem_wben", 64'(mem_wben), 64'd0);
        chk("wr_no_xfc_a", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
`ifdef ARB_WRITE_ACK_EN
        chk("wr_ack_xfc", 64'(bcast_xfc), 64'b00010);
        chk("wr_ack_data", 64'(bcast_data), 64'hDEADBEEF);
`else
        chk("wr_no_xfc_b", 64'(bcast_xfc), 64'd0);
`endif
        @(negedge clk);
        chk("raw_xfc", 64'(bcast_xfc), 64'b00010);
        chk("raw_data", 64'(bcast_data), 64'h1111A5A5);

        // Write from engine 3: acked only when the write-ack feature is built in
        @(negedge clk);
        set_req(3, OP_WRITE, 16'h0030, 32'h12345678, 4'hF);
        req_rts = 5'b01000;
        #1 chk("wr3_rtr", 64'(req_rtr), 64'b01000);
        @(negedge clk);
        req_rts = '0;
        @(negedge clk);
        chk("wr3_xfc_early", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
`ifdef ARB_WRITE_ACK_EN
        chk("wr3_xfc", 64'(bcast_xfc), 64'b01000);
`else
        chk("wr3_xfc", 64'(bcast_xfc), 64'd0);
`endif
        chk("wr3_data", 64'(bcast_data), 64'h1111A5A5);
        repeat (3) @(negedge clk);

        // Pointer is back at 0 only after a reset; start the table from one.
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, OP_READ, 16'(i), 32'h0, 4'hF);
        for (int v = 0; v < 22; v++) begin
            @(negedge clk);
            req_rts = vecs[v].rts;
            #1 chk($sformatf("rr_vec%0d", v), 64'(req_rtr), 64'(vecs[v].rtr));
        end
        @(negedge clk);
        req_rts = '0;
        repeat (5) @(negedge clk);

        // Reset while a read is in flight
        set_req(2, OP_READ, 16'h0010, 32'h0, 4'hF);
        req_rts = 5'b00100;
        #1 chk("mr_rtr", 64'(req_rtr), 64'b00100);
        @(negedge clk);
        req_rts = '0;
        chk("mr_mem_en", 64'(mem_en), 64'd1);
        #1 rst_ = 1'b0;
        #1;
        chk("mr_rst_mem_en", 64'(mem_en), 64'd0);
        chk("mr_rst_addr", 64'(mem_addr), 64'd0);
        chk("mr_rst_data", 64'(bcast_data), 64'd0);
        chk("mr_rst_xfc", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
        rst_ = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mr_no_xfc%0d", c), 64'(bcast_xfc), 64'd0);
        end
        req_rts = 5'b11111;
        #1 chk("mr_ptr0", 64'(req_rtr), 64'b00001);
        @(negedge clk);
        req_rts = '0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
